load_store_unit: RTL and testbench

Initiator-side memory access engine between the CPU execute stage and `memory_unit`. Accepts one load or store request at a time from the core and drives the word-wide `memory_unit` port (`we`, `addr`, `data_write`, `data_read`). Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write, because the memory port has no byte enables. Misaligned or illegal requests are rejected with an error response and make no memory access.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/load_store_align.sv | 84 ++++++++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - FSM state encoding
//   - helper that sizes the READ-phase down-counter
package lsu_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // The counter must hold the value MEM_LATENCY. It is never narrower than
  // 1 bit, so the zero-latency case still has a legal vector.
  function automatic int cnt_width(input int latency);
    if (latency < 1) return 1;
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the load/store unit.
//   chk_we, chk_funct3, chk_addr -> chk_err : legality/alignment of an incoming request
//   op_funct3, op_addr, rdata    -> load_data : extracted and extended load result
//   op_funct3, op_addr, op_wdata, rdata -> store_word : read word with SB/SH lanes replaced
// Lanes are little-endian. Lane k is rdata[8k+7:8k]. A halfword occupies lanes
// {2*addr[1], 2*addr[1]+1}.
module load_store_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          chk_we,
  input  logic [2:0]    chk_funct3,
  input  logic [1:0]    chk_addr,
  output logic          chk_err,
  input  logic [2:0]    op_funct3,
  input  logic [1:0]    op_addr,
  input  logic [15:0]   op_wdata,
  input  logic [N-1:0]  rdata,
  output logic [N-1:0]  load_data,
  output logic [N-1:0]  store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Legality and alignment check for the request being offered.
  always_comb begin
    chk_err = 1'b0;
    if (chk_we) begin
      case (chk_funct3)
        F3_SB:   chk_err = 1'b0;
        F3_SH:   chk_err = chk_addr[0];
        F3_SW:   chk_err = (chk_addr != 2'b00);
        default: chk_err = 1'b1;
      endcase
    end else begin
      case (chk_funct3)
        F3_LB, F3_LBU: chk_err = 1'b0;
        F3_LH, F3_LHU: chk_err = chk_addr[0];
        F3_LW:         chk_err = (chk_addr != 2'b00);
        default:       chk_err = 1'b1;
      endcase
    end
  end

  // Load extraction and extension.
  always_comb begin
    case (op_addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = op_addr[1] ? rdata[31:16] : rdata[15:0];

    case (op_funct3)
      F3_LB:   load_data = {{(N-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {{(N-8){1'b0}}, byte_sel};
      F3_LH:   load_data = {{(N-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {{(N-16){1'b0}}, half_sel};
      F3_LW:   load_data = rdata;
      default: load_data = '0;
    endcase
  end

  // Store merge. Only SB and SH go through the read-modify-write path. SW
  // bypasses this word, so any non-SH code is treated as a byte write.
  always_comb begin
    store_word = rdata;
    if (op_funct3 == F3_SH) begin
      if (op_addr[1]) store_word[31:16] = op_wdata;
      else            store_word[15:0]  = op_wdata;
    end else begin
      case (op_addr)
        2'd0:    store_word[7:0]   = op_wdata[7:0];
        2'd1:    store_word[15:8]  = op_wdata[7:0];
        2'd2:    store_word[23:16] = op_wdata[7:0];
        default: store_word[31:24] = op_wdata[7:0];
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store engine in front of a word-wide memory port
// with no byte enables.
// Ports:
//   clk, rst                  : clock; synchronous active-high reset
//   req_valid/req_ready       : request handshake. A request is accepted on a rising
//                               edge where both are high. req_ready is high only in
//                               IDLE with rst low. req_* are sampled only at accept.
//   req_we, req_funct3, req_addr, req_wdata : request fields
//   resp_valid, resp_rdata, resp_err : one-cycle completion pulse with its data/error
//   mem_we, mem_addr, mem_data_write, mem_data_read : memory_unit port
//   dbg_state                 : current FSM state (lsu_state_e encoding)
// Flow:
//   - Errors go IDLE->RESP.
//   - SW goes IDLE->WRITE->RESP.
//   - Loads go IDLE->READ->RESP.
//   - SB/SH go IDLE->READ->WRITE->RESP.
//   READ holds for MEM_LATENCY+1 cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N           = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [N-1:0]  req_addr,
  input  logic [N-1:0]  req_wdata,
  output logic          resp_valid,
  output logic [N-1:0]  resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [N-1:0]  mem_addr,
  output logic [N-1:0]  mem_data_write,
  input  logic [N-1:0]  mem_data_read,
  output logic [1:0]    dbg_state
);

  localparam int CW = cnt_width(MEM_LATENCY);

  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [N-1:0]    addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [N-1:0]    word_q, word_d;    // word to be written in WRITE
  logic [N-1:0]    rdata_q, rdata_d;  // load result shown in RESP
  logic            err_q, err_d;

  logic            chk_err;
  logic [N-1:0]    load_data;
  logic [N-1:0]    store_word;

  load_store_align #(.N(N)) u_align (
    .chk_we     (req_we),
    .chk_funct3 (req_funct3),
    .chk_addr   (req_addr[1:0]),
    .chk_err    (chk_err),
    .op_funct3  (f3_q),
    .op_addr    (addr_q[1:0]),
    .op_wdata   (wdata_q),
    .rdata      (mem_data_read),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata[15:0];
          word_d  = req_wdata;  // final write word for SW; RMW overwrites it
          rdata_d = '0;
          err_d   = chk_err;
          cnt_d   = CW'(MEM_LATENCY);
          if (chk_err)                          state_d = ST_RESP;
          else if (req_we && req_funct3 == F3_SW) state_d = ST_WRITE;
          else                                  state_d = ST_READ;
        end
      end
      ST_READ: begin
        // mem_data_read is valid on the last READ cycle.
        if (cnt_q == '0) begin
          if (we_q) begin
            word_d  = store_word;
            state_d = ST_WRITE;
          end else begin
            rdata_d = load_data;
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state. The memory port idles at zero.
  always_comb begin
    req_ready      = (state_q == ST_IDLE) && !rst;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = '0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_data_write = '0;
    dbg_state      = state_q;
    case (state_q)
      ST_READ: begin
        mem_addr = {addr_q[N-1:2], 2'b00};
      end
      ST_WRITE: begin
        mem_we         = 1'b1;
        mem_addr       = {addr_q[N-1:2], 2'b00};
        mem_data_write = word_q;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit. It has three instances, with MEM_LATENCY 0, 1 and 3.
// Only the instance chosen by sel sees req_valid. A shared behavioural memory
// serves whichever instance is active. The bench model predicts every output for
// each cycle from the request rules, and one compare process checks against it.
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- request drive ----------------
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  int          sel = 1;

  logic        i_valid [3];
  logic        o_ready [3];
  logic        o_rv    [3];
  logic        o_err   [3];
  logic        o_we    [3];
  logic [31:0] o_rd    [3];
  logic [31:0] o_addr  [3];
  logic [31:0] o_wd    [3];
  logic [31:0] i_rdata [3];
  logic [1:0]  o_dbg   [3];

  always_comb begin
    i_valid[0] = req_valid && (sel == 0);
    i_valid[1] = req_valid && (sel == 1);
    i_valid[2] = req_valid && (sel == 2);
  end

  load_store_unit #(.N(32), .MEM_LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(i_valid[0]), .req_ready(o_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(o_rv[0]), .resp_rdata(o_rd[0]), .resp_err(o_err[0]),
    .mem_we(o_we[0]), .mem_addr(o_addr[0]), .mem_data_write(o_wd[0]),
    .mem_data_read(i_rdata[0]), .dbg_state(o_dbg[0]));

  load_store_unit #(.N(32), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(i_valid[1]), .req_ready(o_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(o_rv[1]), .resp_rdata(o_rd[1]), .resp_err(o_err[1]),
    .mem_we(o_we[1]), .mem_addr(o_addr[1]), .mem_data_write(o_wd[1]),
    .mem_data_read(i_rdata[1]), .dbg_state(o_dbg[1]));

  load_store_unit #(.N(32), .MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(i_valid[2]), .req_ready(o_ready[2]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(o_rv[2]), .resp_rdata(o_rd[2]), .resp_err(o_err[2]),
    .mem_we(o_we[2]), .mem_addr(o_addr[2]), .mem_data_write(o_wd[2]),
    .mem_data_read(i_rdata[2]), .dbg_state(o_dbg[2]));

  // Signals of the active instance
  logic        act_ready, act_rv, act_err, act_we;
  logic [31:0] act_rd, act_addr, act_wd;
  logic [1:0]  act_dbg;
  int          lat;
  always_comb begin
    act_ready = o_ready[sel];
    act_rv    = o_rv[sel];
    act_err   = o_err[sel];
    act_we    = o_we[sel];
    act_rd    = o_rd[sel];
    act_addr  = o_addr[sel];
    act_wd    = o_wd[sel];
    act_dbg   = o_dbg[sel];
    lat       = (sel == 0) ? 0 : ((sel == 1) ? 1 : 3);
  end

  // ---------------- memory stand-in ----------------
  logic [31:0] mem_arr [0:255];
  logic [31:0] p1 = 32'h0, p2 = 32'h0, p3 = 32'h0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'h0;
  logic [31:0] poke_val = 32'h0;

  always @(posedge clk) begin
    if (poke_en)     mem_arr[poke_idx] <= poke_val;
    else if (act_we) mem_arr[act_addr[9:2]] <= act_wd;
    p1 <= mem_arr[act_addr[9:2]];
    p2 <= p1;
    p3 <= p2;
  end

  always_comb begin
    i_rdata[0] = mem_arr[o_addr[0][9:2]];
    i_rdata[1] = p1;
    i_rdata[2] = p3;
  end

  // ---------------- model ----------------
  bit [31:0] ref_mem   [0:255];
  bit        exp_we_a  [4096];
  bit [31:0] exp_addr_a[4096];
  bit [31:0] exp_wd_a  [4096];
  bit        exp_rv_a  [4096];
  bit        exp_err_a [4096];
  bit [31:0] exp_rd_a  [4096];
  int        busy_until = -1;

  int n_checks = 0;
  int n_fail   = 0;

  int        last_resp_cyc = 0, last_we_cyc = 0, we_count = 0, resp_count = 0;
  logic [31:0] last_rdata = 0, last_wd = 0;
  logic      last_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Records what must happen for a request accepted in cycle t.
  task automatic model_accept(input int t, input bit we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
    int          off = int'(a & 32'd3);
    int          idx = int'((a >> 2) & 32'd255);
    logic [31:0] aa  = a & 32'hFFFF_FFFC;
    logic [31:0] w   = ref_mem[idx];
    logic [31:0] v, mask, m;
    int          sh  = 8 * off;
    bit          err;
    if (!we)
      err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
            ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) || (f3 == 3'd2 && off != 0);
    else
      err = (f3 > 3'd2) || (f3 == 3'd1 && (off % 2 != 0)) || (f3 == 3'd2 && off != 0);

    if (err) begin
      exp_rv_a[t+1] = 1; exp_err_a[t+1] = 1; busy_until = t + 1;
    end else if (we && f3 == 3'd2) begin
      exp_we_a[t+1] = 1; exp_addr_a[t+1] = aa; exp_wd_a[t+1] = wd;
      ref_mem[idx] = wd;
      exp_rv_a[t+2] = 1; busy_until = t + 2;
    end else begin
      for (int k = 1; k <= lat + 1; k++) exp_addr_a[t+k] = aa;
      if (!we) begin
        if (f3 == 3'd2) v = w;
        else if (f3 == 3'd0 || f3 == 3'd4) begin
          v = (w >> sh) & 32'hFF;
          if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else begin
          v = (w >> sh) & 32'hFFFF;
          if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        exp_rv_a[t+lat+2] = 1; exp_rd_a[t+lat+2] = v; busy_until = t + lat + 2;
      end else begin
        mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
        m = (w & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[idx] = m;
        exp_we_a[t+lat+2] = 1; exp_addr_a[t+lat+2] = aa; exp_wd_a[t+lat+2] = m;
        exp_rv_a[t+lat+3] = 1; busy_until = t + lat + 3;
      end
    end
  endtask

  // A reset edge at the end of cycle r drops everything that was still pending.
  task automatic model_reset(input int r);
    for (int c = r + 1; c < r + 12 && c < 4096; c++) begin
      exp_we_a[c] = 0; exp_addr_a[c] = 0; exp_wd_a[c] = 0;
      exp_rv_a[c] = 0; exp_err_a[c] = 0; exp_rd_a[c] = 0;
    end
    busy_until = r;
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc < 4096) begin
        bit exp_ready;
        exp_ready = !rst && (cyc > busy_until);
        check("req_ready",      act_ready, exp_ready);
        check("mem_we",         act_we,    exp_we_a[cyc]);
        check("mem_addr",       act_addr,  exp_addr_a[cyc]);
        check("mem_data_write", act_wd,    exp_wd_a[cyc]);
        check("resp_valid",     act_rv,    exp_rv_a[cyc]);
        check("resp_err",       act_err,   exp_err_a[cyc]);
        check("resp_rdata",     act_rd,    exp_rd_a[cyc]);
        if (exp_ready) check("idle_state", act_dbg, 2'd0);
        if (act_rv) begin
          last_resp_cyc = cyc; last_rdata = act_rd; last_err = act_err; resp_count++;
        end
        if (act_we) begin
          last_we_cyc = cyc; last_wd = act_wd; we_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1; poke_idx = 8'(idx); poke_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 0;
  endtask

  // Presents a request and leaves req_valid high. Returns the accept cycle.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int t_acc);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!(!rst && cyc > busy_until) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no accept within 50 cycles, expected accept");
      t_acc = -1;
    end else begin
      t_acc = cyc;
      model_accept(cyc, we, f3, a, wd);
    end
  endtask

  task automatic idle_wait();
    int n = 0;
    @(negedge clk);
    req_valid = 0;
    while (cyc <= busy_until && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got busy after 100 cycles, expected idle");
    end
  endtask

  // ---------------- test sequence ----------------
  int t, t2, wc, rc;
  int gap_tab [3];
  int sb_tab  [3];

  initial begin
    gap_tab[0] = 3; gap_tab[1] = 4; gap_tab[2] = 6;  // accept-to-accept gap: LW then next
    sb_tab[0]  = 3; sb_tab[1]  = 4; sb_tab[2]  = 6;  // SB response latency L+3

    sel = 1;
    repeat (3) @(negedge clk);
    check("rst_ready", act_ready, 1'b0);
    check("rst_resp_valid", act_rv, 1'b0);
    check("rst_mem_addr", act_addr, 32'h0);
    rst = 0;

    // SW
    do_req(1, SW, 32'h0010_0004, 32'hDEAD_BEEF, t);
    idle_wait();
    check("sw_we_lat", last_we_cyc - t, 1);
    check("sw_wdata", last_wd, 32'hDEAD_BEEF);
    check("sw_resp_lat", last_resp_cyc - t, 2);
    check("sw_err", last_err, 1'b0);

    // Byte and halfword loads
    poke(1, 32'h8070_FF12);
    do_req(0, LB, 32'h0010_0005, 32'h0, t);  idle_wait();
    check("lb_rdata", last_rdata, 32'hFFFF_FFFF);
    check("lb_lat", last_resp_cyc - t, 3);
    do_req(0, LBU, 32'h0010_0005, 32'h0, t); idle_wait();
    check("lbu_rdata", last_rdata, 32'h0000_00FF);
    do_req(0, LH, 32'h0010_0006, 32'h0, t);  idle_wait();
    check("lh_rdata", last_rdata, 32'hFFFF_8070);
    do_req(0, LHU, 32'h0010_0004, 32'h0, t); idle_wait();
    check("lhu_rdata", last_rdata, 32'h0000_FF12);
    check("lhu_lat", last_resp_cyc - t, 3);

    // Sub-word stores
    poke(1, 32'h1122_3344);
    wc = we_count;
    do_req(1, SB, 32'h0010_0007, 32'hFFFF_FFAB, t); idle_wait();
    check("sb_wdata", last_wd, 32'hAB22_3344);
    check("sb_we_lat", last_we_cyc - t, 3);
    check("sb_we_once", we_count - wc, 1);
    poke(1, 32'h1122_3344);
    wc = we_count;
    do_req(1, SH, 32'h0010_0004, 32'h0000_BEEF, t); idle_wait();
    check("sh_wdata", last_wd, 32'h1122_BEEF);
    check("sh_we_once", we_count - wc, 1);

    // Error requests
    wc = we_count;
    do_req(0, LW, 32'h0010_0002, 32'h0, t); idle_wait();
    check("lw_mis_err", last_err, 1'b1);
    check("lw_mis_lat", last_resp_cyc - t, 1);
    check("lw_mis_rdata", last_rdata, 32'h0);
    do_req(1, SH, 32'h0010_0001, 32'h1234, t); idle_wait();
    check("sh_mis_err", last_err, 1'b1);
    check("sh_mis_lat", last_resp_cyc - t, 1);
    do_req(0, 3'b011, 32'h0010_0004, 32'h0, t); idle_wait();
    check("ld011_err", last_err, 1'b1);
    check("err_no_we", we_count - wc, 0);

    // Reset during the READ phase of an SB
    wc = we_count; rc = resp_count;
    do_req(1, SB, 32'h0010_0007, 32'h0000_00AB, t);
    @(negedge clk);
    rst = 1; req_valid = 0;
    model_reset(cyc);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    check("ready_after_rst", act_ready, 1'b1);
    repeat (6) @(negedge clk);
    check("rst_no_we", we_count - wc, 0);
    check("rst_no_resp", resp_count - rc, 0);

    // Back-to-back with req_valid held, at each latency
    for (int s = 0; s < 3; s++) begin
      sel = s;
      poke(1, 32'hCAFE_0180);
      do_req(0, LW, 32'h0010_0004, 32'h0, t);
      do_req(1, SW, 32'h0010_0008, 32'h1234_5678 + s, t2);
      idle_wait();
      check("b2b_gap", t2 - t, gap_tab[s]);
      check("b2b_sw_lat", last_resp_cyc - t2, 2);
      do_req(1, SB, 32'h0010_0006, 32'h0000_0055, t); idle_wait();
      check("sb_lat_by_L", last_resp_cyc - t, sb_tab[s]);
      check("sb_word_by_L", last_wd, 32'hCA55_0180);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
